// File: rtl/adau1761_spi_responder_if.sv
// SPI pin bundle between an initiator (master) and the ADAU1761-style responder (slave).
interface adau1761_spi_responder_if;
    logic cs;
    logic sdi;
    logic sdo;

    modport master (output cs, output sdi, input sdo);
    modport slave  (input cs, input sdi, output sdo);
endinterface

// File: rtl/adau1761_spi_responder.sv
// ADAU1761-style SPI register responder: 32-bit frames (ctrl, addr16, data) into a 256x8 register file.
// Optional lock sequence (LOCK_FRAMES cs rises before SPI mode) enabled by ADAU1761_SPI_RESPONDER_LOCK_EN.
module adau1761_spi_responder #(
    parameter logic [7:0] ADDR_PAGE   = 8'h40,
    parameter int         LOCK_FRAMES = 3
) (
    input  logic                            clk,
    input  logic                            resetn,
    adau1761_spi_responder_if.slave         spi,
    output logic                            spi_mode,
    output logic                            wr_strobe,
    output logic [7:0]                      wr_addr,
    output logic [7:0]                      wr_data,
    output logic                            frame_error,
    input  logic [7:0]                      dbg_addr,
    output logic [7:0]                      dbg_data
);

    typedef enum logic [1:0] {LOCK, IDLE, SHIFT, DONE} state_t;

    state_t      state, state_nxt;
    logic [5:0]  bit_cnt;
    logic [30:0] shreg;
    logic [7:0]  regs [256];
    logic [7:0]  rd_sh;
    logic [3:0]  rd_cnt;
    logic        lock_done;

    logic        sample;
    logic        hit24, hit32;
    logic [23:0] word24;
    logic [31:0] word32;
    logic        rd_ok, wr_ok;

`ifdef ADAU1761_SPI_RESPONDER_LOCK_EN
    localparam state_t RST_STATE = LOCK;
    logic       cs_q;
    logic [7:0] lock_cnt;
    logic       cs_rise;

    assign cs_rise   = ~cs_q & spi.cs;
    assign lock_done = cs_rise && (lock_cnt == 8'(LOCK_FRAMES - 1));
    assign spi_mode  = (state != LOCK);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cs_q     <= 1'b1;
            lock_cnt <= 8'h00;
        end else begin
            cs_q <= spi.cs;
            if (state == LOCK && cs_rise)
                lock_cnt <= lock_cnt + 8'h01;
        end
    end
`else
    localparam state_t RST_STATE = IDLE;
    logic unused_cfg;
    assign unused_cfg = (LOCK_FRAMES == 0);
    assign lock_done  = 1'b0;
    assign spi_mode   = 1'b1;
`endif

    // Frame decode includes the bit being sampled this cycle.
    assign sample = ~spi.cs && (state != LOCK);
    assign hit24  = sample && (bit_cnt == 6'd23);
    assign hit32  = sample && (bit_cnt == 6'd31);
    assign word24 = {shreg[22:0], spi.sdi};
    assign word32 = {shreg, spi.sdi};
    assign rd_ok  = (word24[23:16] == 8'h01) && (word24[15:8] == ADDR_PAGE);
    assign wr_ok  = (word32[31:24] == 8'h00) && (word32[23:16] == ADDR_PAGE);

    assign spi.sdo  = ~spi.cs && (rd_cnt != 4'd0) && rd_sh[7];
    assign dbg_data = regs[dbg_addr];

    always_comb begin
        state_nxt = state;
        case (state)
            LOCK:  if (lock_done)             state_nxt = IDLE;
            IDLE:  if (!spi.cs)               state_nxt = SHIFT;
            SHIFT: if (spi.cs)                state_nxt = IDLE;
                   else if (bit_cnt == 6'd31) state_nxt = DONE;
            DONE:  if (spi.cs)                state_nxt = IDLE;
            default:                          state_nxt = RST_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= RST_STATE;
            bit_cnt     <= 6'd0;
            shreg       <= 31'd0;
            rd_sh       <= 8'h00;
            rd_cnt      <= 4'd0;
            wr_strobe   <= 1'b0;
            wr_addr     <= 8'h00;
            wr_data     <= 8'h00;
            frame_error <= 1'b0;
            for (int i = 0; i < 256; i++)
                regs[i] <= 8'h00;
        end else begin
            state       <= state_nxt;
            wr_strobe   <= 1'b0;
            frame_error <= (state == SHIFT) && spi.cs;

            if (spi.cs)
                bit_cnt <= 6'd0;
            else if (bit_cnt != 6'd32)
                bit_cnt <= bit_cnt + 6'd1;

            if (sample)
                shreg <= word32[30:0];

            if (spi.cs) begin
                rd_cnt <= 4'd0;
            end else if (hit24) begin
                rd_sh  <= rd_ok ? regs[word24[7:0]] : 8'h00;
                rd_cnt <= 4'd8;
            end else if (rd_cnt != 4'd0) begin
                rd_sh  <= {rd_sh[6:0], 1'b0};
                rd_cnt <= rd_cnt - 4'd1;
            end

            if (hit32 && wr_ok) begin
                regs[word32[15:8]] <= word32[7:0];
                wr_strobe          <= 1'b1;
                wr_addr            <= word32[15:8];
                wr_data            <= word32[7:0];
            end
        end
    end

endmodule

// File: tb/tb_adau1761_spi_responder.sv
// Bench for adau1761_spi_responder: directed vector table, mid-frame reset, randomized frames vs. register model.
module tb_adau1761_spi_responder;

    localparam logic [7:0] PAGE = 8'h40;
`ifdef ADAU1761_SPI_RESPONDER_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic       spi_mode, wr_strobe, frame_error;
    logic [7:0] wr_addr, wr_data, dbg_addr, dbg_data;

    adau1761_spi_responder_if spi ();

    adau1761_spi_responder #(.ADDR_PAGE(PAGE), .LOCK_FRAMES(3)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .spi         (spi),
        .spi_mode    (spi_mode),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_error (frame_error),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] mem [256];

    typedef struct {
        logic [31:0] word;
        int          nbits;
        logic [7:0]  exp_rd;
        int          exp_strobe;
        int          exp_ferr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic peek(input logic [7:0] a, output logic [7:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    // Drives one frame of nbits with cs low, then 3 idle cycles; observes outputs mid-cycle.
    task automatic run_frame(input logic [31:0] w, input int nbits,
                             output logic [7:0] rd, output int strobes,
                             output logic [7:0] sa, output logic [7:0] sd,
                             output int ferrs, output int stray);
        rd = 8'h00; strobes = 0; sa = 8'h00; sd = 8'h00; ferrs = 0; stray = 0;
        for (int i = 0; i < nbits + 3; i++) begin
            @(negedge clk);
            if (i < nbits) begin
                spi.cs  = 1'b0;
                spi.sdi = (i < 32) ? w[31 - i] : 1'($urandom);
            end else begin
                spi.cs  = 1'b1;
                spi.sdi = 1'b0;
            end
            #1;
            if (i >= 24 && i < 32 && i < nbits) rd[31 - i] = spi.sdo;
            else if (spi.sdo) stray++;
            if (wr_strobe) begin
                strobes++;
                sa = wr_addr;
                sd = wr_data;
            end
            if (frame_error) ferrs++;
        end
    endtask

    // Reference model: frame rules applied to a plain register array.
    task automatic model_frame(input logic [31:0] w, input int nbits, input string tag);
        logic [7:0] ctrl, hi, lo, d, rd, sa, sd, exp_rd, got;
        int         strobes, ferrs, stray;
        bit         exp_wr;
        ctrl = w[31:24]; hi = w[23:16]; lo = w[15:8]; d = w[7:0];
        exp_rd = (ctrl == 8'h01 && hi == PAGE) ? mem[lo] : 8'h00;
        exp_wr = (nbits >= 32) && (ctrl == 8'h00) && (hi == PAGE);
        run_frame(w, nbits, rd, strobes, sa, sd, ferrs, stray);
        check({tag, " strobes"}, 32'(strobes), exp_wr ? 32'd1 : 32'd0);
        if (exp_wr) begin
            check({tag, " wr_addr"}, 32'(sa), 32'(lo));
            check({tag, " wr_data"}, 32'(sd), 32'(d));
            mem[lo] = d;
        end
        if (nbits >= 32) check({tag, " rd"}, 32'(rd), 32'(exp_rd));
        check({tag, " ferr"}, 32'(ferrs), (nbits < 32) ? 32'd1 : 32'd0);
        check({tag, " stray sdo"}, 32'(stray), 32'd0);
        peek(lo, got);
        check({tag, " dbg"}, 32'(got), 32'(mem[lo]));
    endtask

    task automatic do_lock();
        logic [7:0] rd, sa, sd, got;
        int         strobes, ferrs, stray;
        for (int f = 0; f < 3; f++) begin
            run_frame((f == 0) ? 32'h00_40_0A_5B : 32'h0, 32, rd, strobes, sa, sd, ferrs, stray);
            check($sformatf("lock%0d strobe", f), 32'(strobes), 32'd0);
            check($sformatf("lock%0d ferr", f), 32'(ferrs), 32'd0);
            check($sformatf("lock%0d sdo", f), 32'(stray + int'(rd != 0)), 32'd0);
            check($sformatf("lock%0d spi_mode", f), 32'(spi_mode), (f == 2) ? 32'd1 : 32'd0);
        end
        peek(8'h0A, got);
        check("lock no write 0x0A", 32'(got), 32'h00);
    endtask

    initial begin
        vec_t       vecs [14];
        logic [7:0] rd, sa, sd, got;
        int         strobes, ferrs, stray, nb;
        logic [31:0] w;
        logic [7:0] ctrl_opts [4];

        vecs[0]  = '{32'h00_40_00_01, 32, 8'h00, 1, 0};
        vecs[1]  = '{32'h00_40_23_F7, 32, 8'h00, 1, 0};
        vecs[2]  = '{32'h01_40_23_00, 32, 8'hF7, 0, 0};
        vecs[3]  = '{32'h00_50_23_AA, 32, 8'h00, 0, 0};
        vecs[4]  = '{32'h01_50_23_00, 32, 8'h00, 0, 0};
        vecs[5]  = '{32'h00_40_19_03, 20, 8'h00, 0, 1};
        vecs[6]  = '{32'h01_40_19_00, 32, 8'h00, 0, 0};
        vecs[7]  = '{32'h00_40_19_03, 32, 8'h00, 1, 0};
        vecs[8]  = '{32'h01_40_19_00, 32, 8'h03, 0, 0};
        vecs[9]  = '{32'h02_40_05_66, 32, 8'h00, 0, 0};
        vecs[10] = '{32'h03_40_23_00, 32, 8'h00, 0, 0};
        vecs[11] = '{32'h00_40_05_3C, 40, 8'h00, 1, 0};
        vecs[12] = '{32'h01_40_05_00, 40, 8'h3C, 0, 0};
        vecs[13] = '{32'h01_40_00_00, 32, 8'h01, 0, 0};
        ctrl_opts[0] = 8'h00; ctrl_opts[1] = 8'h01; ctrl_opts[2] = 8'h02; ctrl_opts[3] = 8'h03;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        resetn = 1'b0; spi.cs = 1'b1; spi.sdi = 1'b0; dbg_addr = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check("rst sdo", 32'(spi.sdo), 32'd0);
        check("rst wr_strobe", 32'(wr_strobe), 32'd0);
        check("rst frame_error", 32'(frame_error), 32'd0);
        check("rst spi_mode", 32'(spi_mode), LOCK_EN ? 32'd0 : 32'd1);
        peek(8'hFF, got);
        check("rst dbg 0xFF", 32'(got), 32'h00);
        @(negedge clk);
        resetn = 1'b1;

        if (LOCK_EN) do_lock();

        foreach (vecs[i]) begin
            run_frame(vecs[i].word, vecs[i].nbits, rd, strobes, sa, sd, ferrs, stray);
            check($sformatf("vec%0d strobes", i), 32'(strobes), 32'(vecs[i].exp_strobe));
            if (vecs[i].exp_strobe != 0) begin
                check($sformatf("vec%0d wr_addr", i), 32'(sa), 32'(vecs[i].word[15:8]));
                check($sformatf("vec%0d wr_data", i), 32'(sd), 32'(vecs[i].word[7:0]));
                mem[vecs[i].word[15:8]] = vecs[i].word[7:0];
            end
            if (vecs[i].nbits >= 32) check($sformatf("vec%0d rd", i), 32'(rd), 32'(vecs[i].exp_rd));
            check($sformatf("vec%0d ferr", i), 32'(ferrs), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d stray sdo", i), 32'(stray), 32'd0);
        end
        peek(8'h00, got);
        check("dbg 0x00", 32'(got), 32'h01);
        peek(8'h19, got);
        check("dbg 0x19", 32'(got), 32'h03);
        peek(8'h23, got);
        check("dbg 0x23", 32'(got), 32'hF7);

        for (int n = 0; n < 60; n++) begin
            w[31:24] = ctrl_opts[$urandom_range(0, 3)];
            w[23:16] = ($urandom_range(0, 3) != 0) ? PAGE : 8'($urandom);
            w[15:8]  = 8'($urandom_range(0, 7));
            w[7:0]   = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       nb = $urandom_range(1, 31);
                1:       nb = $urandom_range(33, 40);
                default: nb = 32;
            endcase
            model_frame(w, nb, $sformatf("rnd%0d", n));
        end

        // Reset on the 28th bit of a valid write must abort it silently and clear the register file.
        w = 32'h00_40_F9_7F;
        strobes = 0; ferrs = 0;
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            spi.cs = 1'b0;
            spi.sdi = w[31 - i];
            if (i == 27) resetn = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            resetn = 1'b1;
            spi.cs = 1'b1;
            #1;
            if (wr_strobe) strobes++;
            if (frame_error) ferrs++;
        end
        check("midrst strobe", 32'(strobes), 32'd0);
        check("midrst ferr", 32'(ferrs), 32'd0);
        check("midrst spi_mode", 32'(spi_mode), LOCK_EN ? 32'd0 : 32'd1);
        peek(8'hF9, got);
        check("midrst dbg 0xF9", 32'(got), 32'h00);
        peek(8'h23, got);
        check("midrst dbg 0x23 cleared", 32'(got), 32'h00);
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        if (LOCK_EN) do_lock();
        model_frame(32'h00_40_F9_7F, 32, "post write");
        model_frame(32'h01_40_F9_00, 32, "post read");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
